pm_seq: RTL and testbench

Processor state sequencer for the P-M microinstruction unit: owns the state register (P0–P5, K1, K2) and generates the STROB1/STROB2/GOT phase timing that P-M uses to clock its internal flip-flops. Samples P-M's transition requests (EP0–EP5, EK1, EK2) at the end of every state and selects the next state. Runs the memory handshake for states that need a bus cycle. Sits between the control panel/run logic and P-M, replacing free-running strobe timing with one deterministic clocked sequencer.

---
 rtl/pm_seq.sv | 216 +++++++++++++++++++++
 tb/tb_pm_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pm_seq.sv
// pm_seq: processor state sequencer for the P-M microinstruction unit.
// It holds the state register (P0-P5, K1, K2) and runs the phase sequence
// HOLD -> S1 -> [MW] -> S2 -> GOT. While a phase runs it drives the
// STROB1/STROB2/GOT strobes and the memory handshake. All outputs are
// registered.
// Optional feature: define PM_SEQ_NOANS_TIMEOUT_EN to build the memory
// no-answer timeout. It adds the MW counter and makes the alarm output live.
module pm_seq #(
  parameter int STROB_TICKS = 2,
  parameter int NOANS_TICKS = 255
) (
  input  logic       __clk,
  input  logic       __rst,
  input  logic       run,
  input  logic       pnl_req,
  input  logic [5:0] ep,
  input  logic       ek1,
  input  logic       ek2,
  input  logic       mem_need,
  input  logic       mem_ok,
  output logic [5:0] p_,
  output logic       k1_,
  output logic       k2_,
  output logic       strob1_,
  output logic       strob2_,
  output logic       got_,
  output logic       mem_go,
  output logic       alarm
);

  typedef enum logic [2:0] {
    PH_HOLD = 3'd0,
    PH_S1   = 3'd1,
    PH_MW   = 3'd2,
    PH_S2   = 3'd3,
    PH_GOT  = 3'd4
  } phase_t;

  // State codes: 0..5 = P0..P5, 6 = K1, 7 = K2
  localparam logic [2:0] ST_P0 = 3'd0;
  localparam logic [2:0] ST_K1 = 3'd6;
  localparam logic [2:0] ST_K2 = 3'd7;

  localparam int CW = (STROB_TICKS > 1) ? $clog2(STROB_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STROB_TICKS - 1);

  if (STROB_TICKS < 1) begin : g_strob_range
    $error("pm_seq: STROB_TICKS must be at least 1");
  end
  if (NOANS_TICKS < 1) begin : g_noans_range
    $error("pm_seq: NOANS_TICKS must be at least 1");
  end

  phase_t          phase;
  phase_t          phase_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic            timeout;

  logic [5:0]      p_nxt;
  logic            k1_nxt;
  logic            k2_nxt;
  logic            strob1_nxt;
  logic            strob2_nxt;
  logic            got_nxt;
  logic            mem_go_nxt;
  logic            alarm_nxt;

  // Request arbitration: ek2 > ek1 > ep0 > ep5 > ep4 > ep3 > ep2 > ep1, else P0
  function automatic logic [2:0] pick_next(input logic [5:0] req_ep,
                                           input logic       req_ek1,
                                           input logic       req_ek2);
    logic [2:0] nxt;
    if (req_ek2)        nxt = ST_K2;
    else if (req_ek1)   nxt = ST_K1;
    else if (req_ep[0]) nxt = 3'd0;
    else if (req_ep[5]) nxt = 3'd5;
    else if (req_ep[4]) nxt = 3'd4;
    else if (req_ep[3]) nxt = 3'd3;
    else if (req_ep[2]) nxt = 3'd2;
    else if (req_ep[1]) nxt = 3'd1;
    else                nxt = ST_P0;
    return nxt;
  endfunction

`ifdef PM_SEQ_NOANS_TIMEOUT_EN
  localparam int NW = $clog2(NOANS_TICKS + 1);
  localparam logic [NW-1:0] NOANS_LAST = NW'(NOANS_TICKS - 1);

  logic [NW-1:0] wcnt;
  logic [NW-1:0] wcnt_nxt;

  // No-answer detection and MW clock counting (cleared whenever not in MW)
  always_comb begin
    timeout  = (phase == PH_MW) && !mem_ok && (wcnt == NOANS_LAST);
    wcnt_nxt = wcnt;
    if (phase != PH_MW) begin
      wcnt_nxt = '0;
    end else if (mem_ok || timeout) begin
      wcnt_nxt = '0;
    end else begin
      wcnt_nxt = wcnt + NW'(1);
    end
  end

  // MW clock counter register
  always_ff @(posedge __clk) begin
    if (__rst) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt_nxt;
    end
  end
`else
  // Without the timeout build MW waits for mem_ok indefinitely
  assign timeout = 1'b0;
`endif

  // Phase, strobe counter, state register and registered outputs
  always_ff @(posedge __clk) begin
    if (__rst) begin
      phase   <= PH_HOLD;
      cnt     <= '0;
      state   <= ST_P0;
      p_      <= 6'b111110;
      k1_     <= 1'b1;
      k2_     <= 1'b1;
      strob1_ <= 1'b1;
      strob2_ <= 1'b1;
      got_    <= 1'b1;
      mem_go  <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      cnt     <= cnt_nxt;
      state   <= state_nxt;
      p_      <= p_nxt;
      k1_     <= k1_nxt;
      k2_     <= k2_nxt;
      strob1_ <= strob1_nxt;
      strob2_ <= strob2_nxt;
      got_    <= got_nxt;
      mem_go  <= mem_go_nxt;
      alarm   <= alarm_nxt;
    end
  end

  // Next phase / next state selection
  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt;
    state_nxt = state;
    case (phase)
      PH_HOLD: begin
        cnt_nxt = '0;
        if (run || pnl_req) begin
          phase_nxt = PH_S1;
        end else begin
          phase_nxt = PH_HOLD;
        end
      end
      PH_S1: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          phase_nxt = mem_need ? PH_MW : PH_S2;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PH_MW: begin
        cnt_nxt = '0;
        if (mem_ok || timeout) begin
          phase_nxt = PH_S2;
        end else begin
          phase_nxt = PH_MW;
        end
      end
      PH_S2: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          phase_nxt = PH_GOT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PH_GOT: begin
        cnt_nxt   = '0;
        state_nxt = pick_next(ep, ek1, ek2);
        if ((state_nxt == ST_P0) && !run && !pnl_req) begin
          phase_nxt = PH_HOLD;
        end else begin
          phase_nxt = PH_S1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        phase_nxt = PH_HOLD;
      end
    endcase
  end

  // Output decode of the upcoming phase/state, registered on the same edge
  always_comb begin
    p_nxt      = ~(6'b000001 << state_nxt);
    k1_nxt     = (state_nxt != ST_K1);
    k2_nxt     = (state_nxt != ST_K2);
    strob1_nxt = (phase_nxt != PH_S1);
    strob2_nxt = (phase_nxt != PH_S2);
    got_nxt    = (phase_nxt != PH_GOT);
    mem_go_nxt = (phase_nxt == PH_MW);
    alarm_nxt  = timeout;
  end

endmodule

// File: tb/tb_pm_seq.sv
// Self-checking bench for pm_seq. The reference model works per state cycle:
// it derives the phase timeline from the strobe width, the MW length and the
// no-answer limit. It derives the next state from the request priority list.
module tb_pm_seq;

  localparam int ST    = 2;
  localparam int NOANS = 4;
`ifdef PM_SEQ_NOANS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       pnl_req = 1'b0;
  logic [5:0] ep = 6'd0;
  logic       ek1 = 1'b0;
  logic       ek2 = 1'b0;
  logic       mem_need = 1'b0;
  logic       mem_ok = 1'b0;
  logic [5:0] p_;
  logic       k1_, k2_, strob1_, strob2_, got_, mem_go, alarm;
  logic [12:0] obs_vec;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_state = 3'd0;
  bit         exp_hold = 1'b1;

  always #5 clk = ~clk;

  pm_seq #(.STROB_TICKS(ST), .NOANS_TICKS(NOANS)) dut (
    .__clk(clk), .__rst(rst), .run(run), .pnl_req(pnl_req), .ep(ep),
    .ek1(ek1), .ek2(ek2), .mem_need(mem_need), .mem_ok(mem_ok),
    .p_(p_), .k1_(k1_), .k2_(k2_), .strob1_(strob1_), .strob2_(strob2_),
    .got_(got_), .mem_go(mem_go), .alarm(alarm)
  );

  assign obs_vec = {p_, k1_, k2_, strob1_, strob2_, got_, mem_go, alarm};

  // Expected output vector; s1/s2/g mean "strobe asserted"
  function automatic logic [12:0] expect_vec(input logic [2:0] s, input logic s1,
                                             input logic s2, input logic g,
                                             input logic mg, input logic al);
    logic [7:0] oh;
    oh = 8'd1 << s;
    return {~oh[5:0], ~oh[6], ~oh[7], ~s1, ~s2, ~g, mg, al};
  endfunction

  // Next state from the priority list; req[s] is the request for state s
  function automatic logic [2:0] ref_next(input logic [5:0] r_ep, input logic r_ek1,
                                          input logic r_ek2);
    int order [8];
    logic [7:0] req;
    order = '{7, 6, 0, 5, 4, 3, 2, 1};
    req = {r_ek2, r_ek1, r_ep};
    for (int i = 0; i < 8; i++) begin
      if (req[order[i]]) return 3'(order[i]);
    end
    return 3'd0;
  endfunction

  task automatic drive_junk();
    ep       = 6'($urandom);
    ek1      = 1'($urandom);
    ek2      = 1'($urandom);
    run      = 1'($urandom);
    pnl_req  = 1'($urandom);
    mem_need = 1'($urandom);
    mem_ok   = 1'($urandom);
  endtask

  // Idle clocks in HOLD; optionally raise run or pnl_req on the last one
  task automatic hold_clocks(input int n, input bit rel);
    logic [12:0] want;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      want = expect_vec(exp_state, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== want) begin
        errors++;
        $display("FAIL hold_clk%0d got %b want %b", k, obs_vec, want);
      end
      drive_junk();
      run = 1'b0;
      pnl_req = 1'b0;
      if (rel && k == n - 1) begin
        if ($urandom_range(0, 1) == 0) run = 1'b1;
        else pnl_req = 1'b1;
      end
    end
    if (rel) exp_hold = 1'b0;
  endtask

  // One state cycle starting with its first S1 clock. n = clock of mem_ok
  // within MW (0 = never). Returns aborted=1 after mw_limit MW clocks when
  // nothing ends the wait.
  task automatic do_cycle(input bit mem, input int n, input int mw_limit,
                          input logic [5:0] g_ep, input logic g_ek1, input logic g_ek2,
                          input logic g_run, input logic g_pnl, input bit junk,
                          output bit aborted);
    int mw_len, total, ph;
    bit tmo;
    logic [12:0] want;
    tmo = 1'b0;
    aborted = 1'b0;
    if (!mem) mw_len = 0;
    else if (n != 0 && (!TMO_EN || n <= NOANS)) mw_len = n;
    else if (TMO_EN && mw_limit >= NOANS) begin mw_len = NOANS; tmo = 1'b1; end
    else begin mw_len = mw_limit; aborted = 1'b1; end
    total = aborted ? ST + mw_len : 2 * ST + mw_len + 1;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      ph = (k < ST) ? 1 : (k < ST + mw_len) ? 2 : (k < 2 * ST + mw_len) ? 3 : 4;
      want = expect_vec(exp_state, ph == 1, ph == 3, ph == 4, ph == 2,
                        tmo && (k == ST + mw_len));
      checks++;
      if (obs_vec !== want) begin
        errors++;
        $display("FAIL cycle_clk%0d phase%0d got %b want %b", k, ph, obs_vec, want);
      end
      if (junk) drive_junk();
      else begin
        ep = 6'd0; ek1 = 1'b0; ek2 = 1'b0; run = 1'b1; pnl_req = 1'b0;
        mem_need = 1'b0; mem_ok = 1'b0;
      end
      if (k == ST - 1) mem_need = mem;
      if (ph == 2) mem_ok = !tmo && !aborted && (k == ST + mw_len - 1);
      if (ph == 4) begin
        ep = g_ep; ek1 = g_ek1; ek2 = g_ek2; run = g_run; pnl_req = g_pnl;
      end
    end
    if (!aborted) begin
      exp_state = ref_next(g_ep, g_ek1, g_ek2);
      exp_hold  = (exp_state == 3'd0) && !g_run && !g_pnl;
    end
  endtask

  task automatic next_cycle(input bit mem, input int n, input int mw_limit,
                            input logic [5:0] g_ep, input logic g_ek1, input logic g_ek2,
                            input logic g_run, input logic g_pnl, input bit junk,
                            output bit aborted);
    if (exp_hold) hold_clocks($urandom_range(1, 3), 1'b1);
    do_cycle(mem, n, mw_limit, g_ep, g_ek1, g_ek2, g_run, g_pnl, junk, aborted);
  endtask

  // Reset pulse while MW is still waiting, then idle in HOLD
  task automatic reset_in_mw();
    logic [12:0] want;
    @(negedge clk);
    want = expect_vec(exp_state, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_vec !== want) begin
      errors++;
      $display("FAIL pre_reset_mw got %b want %b", obs_vec, want);
    end
    rst = 1'b1; run = 1'b1; mem_ok = 1'b0;
    @(negedge clk);
    exp_state = 3'd0;
    checks++;
    if (obs_vec !== 13'b1111101111100) begin
      errors++;
      $display("FAIL reset_mid_mw got %b want %b", obs_vec, 13'b1111101111100);
    end
    rst = 1'b0; run = 1'b0; pnl_req = 1'b0;
    exp_hold = 1'b1;
    hold_clocks(4, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_vec !== 13'b1111101111100) begin
      errors++;
      $display("FAIL reset_state got %b want %b", obs_vec, 13'b1111101111100);
    end
    rst = 1'b0; run = 1'b0; pnl_req = 1'b0;
    exp_state = 3'd0;
    exp_hold = 1'b1;
    hold_clocks(10, 1'b0);
  endtask

  task automatic test_basic();
    bit ab;
    hold_clocks(2, 1'b1);
    do_cycle(1'b0, 0, 0, 6'b000010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ab);
    @(posedge clk);
    #1;
    checks++;
    if (p_ !== 6'b111101) begin
      errors++;
      $display("FAIL basic_p1 got %b want %b", p_, 6'b111101);
    end
  endtask

  task automatic test_mem_wait();
    bit ab;
    do_cycle(1'b1, 3, 1000, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ab);
  endtask

  task automatic test_priority();
    bit ab;
    do_cycle(1'b0, 0, 0, 6'b111111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ab);
    @(posedge clk);
    #1;
    checks++;
    if ({p_, k1_, k2_} !== {6'b111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL priority_k2 got %b want %b", {p_, k1_, k2_}, {6'b111111, 1'b1, 1'b0});
    end
    do_cycle(1'b0, 0, 0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ab);
  endtask

  task automatic test_timeout();
    bit ab;
    next_cycle(1'b1, 0, 100, 6'b000100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ab);
`ifdef PM_SEQ_NOANS_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      next_cycle(1'b1, $urandom_range(1, 6), 1000, 6'($urandom), 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b1, ab);
`else
    reset_in_mw();
`endif
  endtask

  task automatic test_reset_mid_mw();
    bit ab;
    next_cycle(1'b1, 0, 2, 6'b001000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ab);
    reset_in_mw();
  endtask

  task automatic test_random();
    bit ab;
    logic [5:0] g_ep;
    for (int i = 0; i < 60; i++) begin
      g_ep = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
      next_cycle(1'($urandom), $urandom_range(1, 6), 1000, g_ep,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'b1, ab);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_wait();
    test_priority();
    test_random();
    test_timeout();
    test_reset_mid_mw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
